// File: rtl/uart_tx_scheduler_if.sv
// Request/response and UART TX handshake bundle for the TX scheduler.
// slave is the scheduler side; master is the system/UART side that drives requests and TX_BUSY.
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    rd_data_vld;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    alu_out_vld;
    logic [2*DATA_WIDTH-1:0] alu_out;
    logic                    tx_busy;
    logic                    clr_err;
    logic [DATA_WIDTH-1:0]   tx_p_data;
    logic                    tx_data_valid;
    logic                    rd_ack;
    logic                    alu_ack;
    logic                    sched_busy;
    logic                    overflow;
    logic                    err;

    modport master (
        output rd_data_vld, rd_data, alu_out_vld, alu_out, tx_busy, clr_err,
        input  tx_p_data, tx_data_valid, rd_ack, alu_ack, sched_busy, overflow, err
    );

    modport slave (
        input  rd_data_vld, rd_data, alu_out_vld, alu_out, tx_busy, clr_err,
        output tx_p_data, tx_data_valid, rd_ack, alu_ack, sched_busy, overflow, err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-requester (register read byte, 16-bit ALU result) scheduler feeding a UART TX one frame
// at a time, paced on TX_BUSY, with round-robin arbitration and a TX_BUSY rise timeout.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int CntW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSend   = 2'd1;
    localparam logic [1:0] StWaitHi = 2'd2;
    localparam logic [1:0] StWaitLo = 2'd3;

    localparam logic GrantRd  = 1'b0;
    localparam logic GrantAlu = 1'b1;

    logic [1:0]              state_q, state_d;
    logic                    pend_rd_q, pend_rd_d;
    logic                    pend_alu_q, pend_alu_d;
    logic [DATA_WIDTH-1:0]   rd_hold_q, rd_hold_d;
    logic [2*DATA_WIDTH-1:0] alu_hold_q, alu_hold_d;
    logic                    last_grant_q, last_grant_d;
    logic                    bytes_left_q, bytes_left_d;
    logic [DATA_WIDTH-1:0]   hi_byte_q, hi_byte_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    rd_ack_q, rd_ack_d;
    logic                    alu_ack_q, alu_ack_d;
    logic                    overflow_q, overflow_d;
    logic                    err_q, err_d;

    logic grant_rd, grant_alu;
    logic rd_take, rd_drop, alu_take, alu_drop;
    logic timeout;

    // Round-robin grant, evaluated only while idle; a tie goes to the requester not granted last.
    always_comb begin
        grant_rd  = 1'b0;
        grant_alu = 1'b0;
        if (state_q == StIdle) begin
            if (pend_rd_q && pend_alu_q) begin
                if (last_grant_q == GrantRd) grant_alu = 1'b1;
                else                         grant_rd  = 1'b1;
            end else if (pend_rd_q) begin
                grant_rd = 1'b1;
            end else if (pend_alu_q) begin
                grant_alu = 1'b1;
            end
        end
    end

    // Request capture, acks and sticky flags; a request into a full, ungranted slot is dropped.
    always_comb begin
        rd_take    = bus.rd_data_vld && (!pend_rd_q || grant_rd);
        rd_drop    = bus.rd_data_vld && pend_rd_q && !grant_rd;
        alu_take   = bus.alu_out_vld && (!pend_alu_q || grant_alu);
        alu_drop   = bus.alu_out_vld && pend_alu_q && !grant_alu;
        pend_rd_d  = rd_take ? 1'b1 : (grant_rd ? 1'b0 : pend_rd_q);
        pend_alu_d = alu_take ? 1'b1 : (grant_alu ? 1'b0 : pend_alu_q);
        rd_hold_d  = rd_take ? bus.rd_data : rd_hold_q;
        alu_hold_d = alu_take ? bus.alu_out : alu_hold_q;
        rd_ack_d   = rd_take;
        alu_ack_d  = alu_take;
        // Set beats clear when both happen in the same cycle.
        overflow_d = (rd_drop || alu_drop) ? 1'b1 : (bus.clr_err ? 1'b0 : overflow_q);
        err_d      = timeout ? 1'b1 : (bus.clr_err ? 1'b0 : err_q);
    end

    // Frame FSM: launch, wait for TX_BUSY to rise (with timeout), wait for it to fall.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bytes_left_d = bytes_left_q;
        hi_byte_d    = hi_byte_q;
        tx_data_d    = tx_data_q;
        cnt_d        = cnt_q;
        timeout      = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_rd) begin
                    tx_data_d    = rd_hold_q;
                    bytes_left_d = 1'b0;
                    last_grant_d = GrantRd;
                    state_d      = StSend;
                end else if (grant_alu) begin
                    tx_data_d    = alu_hold_q[DATA_WIDTH-1:0];
                    hi_byte_d    = alu_hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    bytes_left_d = 1'b1;
                    last_grant_d = GrantAlu;
                    state_d      = StSend;
                end
            end
            StSend: begin
                cnt_d   = '0;
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (bus.tx_busy) begin
                    state_d = StWaitLo;
                end else if (cnt_q == CntLast) begin
                    timeout      = 1'b1;
                    bytes_left_d = 1'b0;
                    state_d      = StIdle;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!bus.tx_busy) begin
                    if (bytes_left_q) begin
                        tx_data_d    = hi_byte_q;
                        bytes_left_d = 1'b0;
                        state_d      = StSend;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_rd_q    <= 1'b0;
            pend_alu_q   <= 1'b0;
            rd_hold_q    <= '0;
            alu_hold_q   <= '0;
            last_grant_q <= GrantRd;
            bytes_left_q <= 1'b0;
            hi_byte_q    <= '0;
            tx_data_q    <= '0;
            cnt_q        <= '0;
            rd_ack_q     <= 1'b0;
            alu_ack_q    <= 1'b0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            pend_alu_q   <= pend_alu_d;
            rd_hold_q    <= rd_hold_d;
            alu_hold_q   <= alu_hold_d;
            last_grant_q <= last_grant_d;
            bytes_left_q <= bytes_left_d;
            hi_byte_q    <= hi_byte_d;
            tx_data_q    <= tx_data_d;
            cnt_q        <= cnt_d;
            rd_ack_q     <= rd_ack_d;
            alu_ack_q    <= alu_ack_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
        end
    end

    assign bus.tx_p_data     = tx_data_q;
    assign bus.tx_data_valid = (state_q == StSend);
    assign bus.rd_ack        = rd_ack_q;
    assign bus.alu_ack       = alu_ack_q;
    assign bus.sched_busy    = (state_q != StIdle);
    assign bus.overflow      = overflow_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: cycle table, directed corner sequences and a
// randomized run against a transaction-timing reference model.
module tb_uart_tx_scheduler;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk;
    logic rst;
    uart_tx_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_scheduler #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // UART TX model: TX_BUSY high for busy_len cycles after each strobe, unless stuck.
    int busy_len = 2;
    bit tx_stuck = 1'b0;
    int busy_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt    <= 0;
            bus.tx_busy <= 1'b0;
        end else if (bus.tx_data_valid && !tx_stuck) begin
            busy_cnt    <= busy_len;
            bus.tx_busy <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt    <= 0;
            bus.tx_busy <= 1'b0;
        end
    end

    // Byte monitor; also counts strobes issued while the TX is still busy.
    logic [7:0] sent_q[$];
    int viol = 0;
    always @(posedge clk) begin
        if (!rst && bus.tx_data_valid) begin
            sent_q.push_back(bus.tx_p_data);
            if (bus.tx_busy) viol <= viol + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [7:0] rd, input logic av,
                         input logic [15:0] ad, input logic clr);
        bus.rd_data_vld = rv;
        bus.rd_data     = rd;
        bus.alu_out_vld = av;
        bus.alu_out     = ad;
        bus.clr_err     = clr;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_stuck = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sent_q.delete();
    endtask

    // Compare the first n monitored bytes against packed bytes (byte 0 in the low bits).
    task automatic check_sent(input string name, input int n, input logic [39:0] exp_bytes);
        logic [39:0] e;
        e = exp_bytes;
        check({name, "_count"}, sent_q.size(), n);
        for (int i = 0; i < n; i++)
            check(name, (i < sent_q.size()) ? {24'h0, sent_q[i]} : 32'hxxxxxxxx, e[8*i +: 8]);
    endtask

    typedef struct {
        logic        rv;
        logic [7:0]  rd;
        logic        av;
        logic [15:0] ad;
        logic        clr;
        logic        e_rack;
        logic        e_aack;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_sbusy;
        logic        e_ovf;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [7:0] rd, input logic av,
                                input logic [15:0] ad, input logic clr, input logic e_rack,
                                input logic e_aack, input logic e_valid, input logic [7:0] e_data,
                                input logic e_sbusy, input logic e_ovf, input logic e_err);
        vec_t v;
        v.rv = rv; v.rd = rd; v.av = av; v.ad = ad; v.clr = clr;
        v.e_rack = e_rack; v.e_aack = e_aack; v.e_valid = e_valid; v.e_data = e_data;
        v.e_sbusy = e_sbusy; v.e_ovf = e_ovf; v.e_err = e_err;
        return v;
    endfunction

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } exp_t;

    initial begin
        vec_t vecs[$];

        // Single read 0xA5 then ALU 0x1234 with a 2-cycle TX frame.
        vecs.push_back(mk(1, 8'hA5, 0, 16'h0000, 0,  0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 1,  0, 0, 0, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 16'h1234, 0,  0, 0, 0, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 1, 0, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h34, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h34, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h34, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h34, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h12, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h12, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h12, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h12, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h12, 0, 0, 0));

        busy_len = 2;
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("tbl%0d_rd_ack", i), bus.rd_ack, vecs[i].e_rack);
            check($sformatf("tbl%0d_alu_ack", i), bus.alu_ack, vecs[i].e_aack);
            check($sformatf("tbl%0d_valid", i), bus.tx_data_valid, vecs[i].e_valid);
            check($sformatf("tbl%0d_data", i), bus.tx_p_data, vecs[i].e_data);
            check($sformatf("tbl%0d_sbusy", i), bus.sched_busy, vecs[i].e_sbusy);
            check($sformatf("tbl%0d_ovf", i), bus.overflow, vecs[i].e_ovf);
            check($sformatf("tbl%0d_err", i), bus.err, vecs[i].e_err);
            drive(vecs[i].rv, vecs[i].rd, vecs[i].av, vecs[i].ad, vecs[i].clr);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);

        // Tie after reset: ALU first; a second ALU request then ties with the held read,
        // and the read wins because ALU was granted last.
        busy_len = 3;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            if (c == 0) drive(1'b1, 8'h11, 1'b1, 16'hBEEF, 1'b0);
            if (c == 3) drive(1'b0, 8'h00, 1'b1, 16'hCAFE, 1'b0);
            if (c == 1) check("tie_rd_ack", bus.rd_ack, 1'b1);
            if (c == 1) check("tie_alu_ack", bus.alu_ack, 1'b1);
            if (c == 2) check("tie_first_data", bus.tx_p_data, 8'hEF);
            if (c == 4) check("tie_alu_ack2", bus.alu_ack, 1'b1);
            tick();
        end
        check_sent("tie_order", 5, {8'hCA, 8'hFE, 8'h11, 8'hBE, 8'hEF});

        // Overflow: a read in the grant cycle is accepted, a read while it is held is dropped.
        busy_len = 2;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            if (c == 0) drive(1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0);
            if (c == 1) drive(1'b1, 8'h66, 1'b0, 16'h0000, 1'b0);
            if (c == 2) drive(1'b1, 8'h77, 1'b0, 16'h0000, 1'b0);
            if (c == 9) drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
            if (c == 2) check("ovf_grant_cycle_ack", bus.rd_ack, 1'b1);
            if (c == 2) check("ovf_not_yet", bus.overflow, 1'b0);
            if (c == 3) check("ovf_drop_no_ack", bus.rd_ack, 1'b0);
            if (c == 3) check("ovf_set", bus.overflow, 1'b1);
            if (c == 7) check("ovf_second_valid", bus.tx_data_valid, 1'b1);
            if (c == 7) check("ovf_second_data", bus.tx_p_data, 8'h66);
            if (c == 9) check("ovf_sticky", bus.overflow, 1'b1);
            if (c == 10) check("ovf_cleared", bus.overflow, 1'b0);
            tick();
        end
        check_sent("ovf_order", 2, {24'h0, 8'h66, 8'h5A});

        // Timeout: TX never answers, ERR at SEND+17, no high byte, next read still served.
        busy_len = 2;
        do_reset();
        tx_stuck = 1'b1;
        for (int c = 0; c < 34; c++) begin
            drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            if (c == 0) drive(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
            if (c == 20) begin
                tx_stuck = 1'b0;
                drive(1'b1, 8'h3C, 1'b0, 16'h0000, 1'b0);
            end
            if (c == 30) drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
            if (c == 2) check("to_send", bus.tx_data_valid, 1'b1);
            if (c == 18) check("to_err_early", bus.err, 1'b0);
            if (c == 18) check("to_busy_before", bus.sched_busy, 1'b1);
            if (c == 19) check("to_err_set", bus.err, 1'b1);
            if (c == 19) check("to_idle", bus.sched_busy, 1'b0);
            if (c == 22) check("to_rd_valid", bus.tx_data_valid, 1'b1);
            if (c == 22) check("to_rd_data", bus.tx_p_data, 8'h3C);
            if (c == 30) check("to_err_sticky", bus.err, 1'b1);
            if (c == 31) check("to_err_cleared", bus.err, 1'b0);
            tick();
        end
        check_sent("to_order", 2, {24'h0, 8'h3C, 8'h34});

        // Reset in WAIT_LO of an ALU low byte, with a second ALU held and OVERFLOW set.
        busy_len = 5;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            if (c == 0) drive(1'b0, 8'h00, 1'b1, 16'hABCD, 1'b0);
            if (c == 1) drive(1'b0, 8'h00, 1'b1, 16'h5555, 1'b0);
            if (c == 2) drive(1'b0, 8'h00, 1'b1, 16'h6666, 1'b0);
            if (c == 4) check("rst_pre_ovf", bus.overflow, 1'b1);
            if (c == 4) check("rst_pre_busy", bus.sched_busy, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_data", bus.tx_p_data, 8'h00);
        check("rst_valid", bus.tx_data_valid, 1'b0);
        check("rst_sbusy", bus.sched_busy, 1'b0);
        check("rst_acks", {bus.rd_ack, bus.alu_ack}, 2'b00);
        check("rst_flags", {bus.overflow, bus.err}, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            check("rst_after_idle", bus.sched_busy, 1'b0);
            tick();
        end
        check_sent("rst_order", 1, {32'h0, 8'hCD});

        // Randomized run against a transaction-timing reference model.
        for (int run = 0; run < 3; run++) begin
            exp_t       sendq[$];
            logic       m_prd, m_palu, m_last, m_ovf, e_rack, e_aack, exp_v;
            logic [7:0] m_hrd;
            logic [15:0] m_halu;
            int         m_free, m_gcyc, len;
            len = (run == 0) ? 1 : int'($urandom_range(2, 6));
            busy_len = len;
            do_reset();
            m_prd = 0; m_palu = 0; m_last = 0; m_ovf = 0; e_rack = 0; e_aack = 0;
            m_hrd = 0; m_halu = 0; m_free = 0; m_gcyc = -1;
            for (int t = 0; t < 380; t++) begin
                logic rv, av, clr, g_rd, g_alu;
                logic [7:0] rd;
                logic [15:0] ad;
                check("rnd_rd_ack", bus.rd_ack, e_rack);
                check("rnd_alu_ack", bus.alu_ack, e_aack);
                check("rnd_ovf", bus.overflow, m_ovf);
                check("rnd_err", bus.err, 1'b0);
                check("rnd_sbusy", bus.sched_busy, (t > m_gcyc) && (t < m_free));
                while (sendq.size() > 0 && sendq[0].cyc < t) void'(sendq.pop_front());
                exp_v = (sendq.size() > 0) && (sendq[0].cyc == t);
                check("rnd_valid", bus.tx_data_valid, exp_v);
                if (exp_v) begin
                    check("rnd_data", bus.tx_p_data, sendq[0].b);
                    void'(sendq.pop_front());
                end

                rv  = (t < 300) && ($urandom_range(0, 5) == 0);
                av  = (t < 300) && ($urandom_range(0, 5) == 0);
                clr = ($urandom_range(0, 19) == 0);
                rd  = 8'($urandom);
                ad  = 16'($urandom);
                drive(rv, rd, av, ad, clr);

                // Grant when the scheduler has drained its last frame sequence.
                g_rd = 0;
                g_alu = 0;
                if (t >= m_free && (m_prd || m_palu)) begin
                    if (m_prd && m_palu) begin
                        g_alu = (m_last == 0);
                        g_rd  = (m_last == 1);
                    end else begin
                        g_rd  = m_prd;
                        g_alu = m_palu;
                    end
                    m_gcyc = t;
                    if (g_rd) begin
                        sendq.push_back('{t + 1, m_hrd});
                        m_free = t + 3 + len;
                        m_last = 0;
                    end else begin
                        sendq.push_back('{t + 1, m_halu[7:0]});
                        sendq.push_back('{t + 3 + len, m_halu[15:8]});
                        m_free = t + 5 + 2 * len;
                        m_last = 1;
                    end
                end
                e_rack = rv && (!m_prd || g_rd);
                e_aack = av && (!m_palu || g_alu);
                if ((rv && !e_rack) || (av && !e_aack)) m_ovf = 1;
                else if (clr) m_ovf = 0;
                if (e_rack) m_hrd = rd;
                if (e_aack) m_halu = ad;
                m_prd  = e_rack ? 1'b1 : (g_rd ? 1'b0 : m_prd);
                m_palu = e_aack ? 1'b1 : (g_alu ? 1'b0 : m_palu);
                tick();
            end
            drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
            check("rnd_drained", sendq.size(), 0);
        end

        check("valid_while_busy", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

- Two-requester scheduler that feeds the UART transmit path: a 1-byte register-read response and a 2-byte ALU result.
- Captures each request into its own holding register and arbitrates round-robin between them.
- Issues bytes to the UART TX one frame at a time, pacing each frame on the TX `Busy` handshake.
- Sits between the system controller datapath and the UART TX wrapper; supervises the TX with a timeout.

## Interface
- `DATA_WIDTH`, 8: byte width of the UART payload.
- `BUSY_TIMEOUT`, 16: max cycles to wait for `TX_BUSY` to rise after a launch.
- `CLK` in 1: single clock, all logic rising-edge.
- `RST` in 1: asynchronous, active-high reset.
- `RD_DATA_VLD` in 1: single-cycle pulse, register-read byte request.
- `RD_DATA` in DATA_WIDTH: register-read byte; valid when `RD_DATA_VLD`=1.
- `ALU_OUT_VLD` in 1: single-cycle pulse, ALU result request.
- `ALU_OUT` in 2*DATA_WIDTH: ALU result; low byte is sent first.
- `TX_BUSY` in 1: UART TX busy flag, already synchronous to `CLK`.
- `CLR_ERR` in 1: clears `OVERFLOW` and `ERR`.
- `TX_P_DATA` out DATA_WIDTH: byte presented to the UART TX.
- `TX_DATA_VALID` out 1: one-cycle launch strobe to the UART TX.
- `RD_ACK` out 1: one-cycle pulse, read request captured.
- `ALU_ACK` out 1: one-cycle pulse, ALU request captured.
- `SCHED_BUSY` out 1: high whenever the state is not IDLE.
- `OVERFLOW` out 1: sticky; a request was dropped.
- `ERR` out 1: sticky; a `TX_BUSY` timeout occurred.

## Operation
- Capture:
  - A VLD pulse loads that requester's holding register and sets its `pend_*` flag.
  - The matching ACK pulses in the next cycle.
  - If `pend_*` is already set and is not being granted that same cycle, the request is dropped: no ACK, and `OVERFLOW` is set.
  - A VLD in the grant cycle is accepted.
- Arbitration happens in IDLE only.
  - Only one pend flag set: that requester wins.
  - Both set: the requester not granted last wins.
  - `last_grant` resets to RD, so ALU wins the first tie.
  - The grant clears the winner's pend flag, loads the byte(s) into the output register, and updates `last_grant`.
  - For an ALU grant, `bytes_left`=1 is also set.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
  - IDLE: any pend set -> SEND (grant performed on this edge).
  - SEND: `TX_DATA_VALID`=1 for exactly one cycle -> WAIT_HI; timeout counter cleared.
  - WAIT_HI, `TX_BUSY`=1 -> WAIT_LO.
  - WAIT_HI, counter reaches `BUSY_TIMEOUT`-1 with `TX_BUSY`=0 -> set `ERR`, discard `bytes_left`, -> IDLE.
  - WAIT_HI otherwise: counter increments.
  - WAIT_LO, `TX_BUSY`=0 with `bytes_left`=1: `TX_P_DATA` <= ALU high byte, `bytes_left`=0, -> SEND.
  - WAIT_LO, `TX_BUSY`=0 with `bytes_left`=0 -> IDLE.
  - WAIT_LO has no timeout; the UART TX bounds the frame length.
- Output data: `TX_P_DATA` is registered and changes only on grant or on the high-byte load. It is stable from SEND through WAIT_LO.
- `CLR_ERR` clears both sticky flags.
  - If `CLR_ERR` and a set event occur in the same cycle, the set wins.
- The timeout counter is ceil(log2(`BUSY_TIMEOUT`)) bits wide and saturates; it never wraps.

## Timing
- Reset: all outputs are 0 and the state is IDLE. Pend flags, `bytes_left`, counter and holding registers clear; `last_grant`=RD.
- Reset mid-frame aborts immediately; the remaining byte is lost. The UART TX is not signalled.
- Latency, scheduler idle: VLD in cycle n -> ACK and pend in n+1 -> SEND (`TX_DATA_VALID`=1) in n+2.
- Back-to-back frames: after `TX_BUSY` falls in cycle m, the next SEND is in cycle m+1 for an ALU high byte, or m+2 for a newly arbitrated request (via IDLE).
- `TX_DATA_VALID` is never asserted while `TX_BUSY`=1.
- Timeout: with `TX_BUSY` stuck at 0, `ERR` rises `BUSY_TIMEOUT`+1 cycles after the SEND cycle, and the state returns to IDLE in the same cycle.
- Requests arriving while busy are held, at most one per requester; they do not disturb the current frame.

## Test plan
- Single read: `RD_DATA`=0xA5, pulse in cycle 0 -> `RD_ACK` in cycle 1, `TX_DATA_VALID`+0xA5 in cycle 2. Model busy 10 cycles -> IDLE, `SCHED_BUSY`=0.
- ALU 16-bit: `ALU_OUT`=0x1234 -> two frames in order 0x34 then 0x12, one strobe each. The second strobe comes 1 cycle after `TX_BUSY` falls.
- Simultaneous VLD after reset: RD=0x11, ALU=0xBEEF -> order 0xEF, 0xBE, 0x11. Repeating the tie next time gives RD first.
- Overflow: second `RD_DATA_VLD` while RD is pending and ungranted -> no ACK, `OVERFLOW`=1, original byte sent. `CLR_ERR` -> `OVERFLOW`=0.
- Timeout: TX model never raises `TX_BUSY`, `BUSY_TIMEOUT`=16, ALU request -> `ERR`=1 at SEND+17, no high byte sent. A subsequent RD request is still serviced.
- `RST` asserted in WAIT_LO of an ALU low byte -> all outputs 0 immediately. After release, the high byte is never sent and pend flags are 0.
